// File: rtl/seg7_scan_if.sv
// Bus between the 7-segment scan controller and its host/display side.
// The master drives capture and enable controls; the slave (controller) drives the display pins.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      en;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   bcd_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [3:0]                bcd_out;
  logic [NUM_DIGITS-1:0]     an_n;
  logic                      dp_out;
  logic                      bad_code;
  logic                      frame_tick;

  modport master (
    output en, load, bcd_in, dp_in,
    input  bcd_out, an_n, dp_out, bad_code, frame_tick
  );

  modport slave (
    input  en, load, bcd_in, dp_in,
    output bcd_out, an_n, dp_out, bad_code, frame_tick
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Optional leading-zero suppression is compiled in when SEG7_LZ_SUPPRESS_EN is defined.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int GUARD      = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  seg7_scan_if.slave bus
);
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(GUARD - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF = '1;

  typedef enum logic {S_GUARD, S_SHOW} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [3:0]              bcd_q, bcd_d;
  logic                    dp_q, dp_d;
  logic                    bad_q, bad_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, tick_d;

  logic [4*NUM_DIGITS-1:0] src_bcd;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic [3:0]              sample_bcd;
  logic                    sample_dp;
  logic [NUM_DIGITS-1:0]   sample_an;

  // A load on the sampling cycle bypasses the shadow so the new value shows immediately.
  always_comb begin
    src_bcd    = bus.load ? bus.bcd_in : shadow_bcd_q;
    src_dp     = bus.load ? bus.dp_in  : shadow_dp_q;
    sample_bcd = 4'd0;
    sample_dp  = 1'b0;
    sample_an  = ALL_OFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        sample_bcd   = src_bcd[4*i +: 4];
        sample_dp    = src_dp[i];
        sample_an[i] = 1'b0;
      end
    end
`ifdef SEG7_LZ_SUPPRESS_EN
    begin
      logic upper_zero;
      upper_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (IW'(i) >= idx_q && src_bcd[4*i +: 4] != 4'd0) upper_zero = 1'b0;
      end
      if (idx_q != '0 && upper_zero && !sample_dp) sample_an = ALL_OFF;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    shadow_bcd_d = bus.load ? bus.bcd_in : shadow_bcd_q;
    shadow_dp_d  = bus.load ? bus.dp_in  : shadow_dp_q;
    bcd_d        = bcd_q;
    dp_d         = dp_q;
    bad_d        = bad_q;
    an_d         = an_q;
    tick_d       = 1'b0;
    if (!bus.en) begin
      state_d = S_GUARD;
      cnt_d   = '0;
      idx_d   = '0;
      an_d    = ALL_OFF;
    end else begin
      case (state_q)
        S_GUARD: begin
          an_d = ALL_OFF;
          if (cnt_q == CNT_SAMPLE) begin
            bcd_d   = sample_bcd;
            dp_d    = sample_dp;
            bad_d   = (sample_bcd > 4'd9);
            an_d    = sample_an;
            state_d = S_SHOW;
          end
        end
        S_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            an_d    = ALL_OFF;
            state_d = S_GUARD;
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              tick_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = S_GUARD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_GUARD;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      bcd_q        <= 4'd0;
      dp_q         <= 1'b0;
      bad_q        <= 1'b0;
      an_q         <= ALL_OFF;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      bcd_q        <= bcd_d;
      dp_q         <= dp_d;
      bad_q        <= bad_d;
      an_q         <= an_d;
      tick_q       <= tick_d;
    end
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.dp_out     = dp_q;
  assign bus.bad_code   = bad_q;
  assign bus.an_n       = an_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It sequences one shared BCD-to-7-segment decoder across NUM_DIGITS digits. It holds a captured shadow copy of the BCD word and drives the decoder's 4-bit BCD input (A = MSB … D = LSB) one digit at a time. It also drives active-low digit enables, with a guard interval between digits to prevent ghosting.

## Interface
- NUM_DIGITS, 4, digits scanned; legal 2..8
- DIV, 50000, clock cycles per digit slot; legal ≥ GUARD+2
- GUARD, 500, blank cycles at the start of each slot; legal ≥ 1
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; 0 blanks the display and restarts the scan
- load  in  1  one-cycle strobe; captures bcd_in and dp_in into the shadow registers
- bcd_in  in  4*NUM_DIGITS  packed BCD; digit i = bcd_in[4i+3:4i]; digit 0 is least significant
- dp_in  in  NUM_DIGITS  decimal-point request per digit
- bcd_out  out  4  BCD code to the decoder, [3]=A … [0]=D
- an_n  out  NUM_DIGITS  active-low digit enables
- dp_out  out  1  decimal point for the active digit, active-high
- bad_code  out  1  high while the active digit's code is 10..15
- frame_tick  out  1  one-cycle pulse at the end of the last digit slot

## Operation
- All outputs are registered. Reset values:
  - an_n all 1; bcd_out 0; dp_out 0; bad_code 0; frame_tick 0.
  - Shadow registers 0; slot counter cnt = 0; digit index idx = 0; state GUARD.
- State machine (tracks cnt, 0..DIV-1):
  - GUARD: cnt 0..GUARD-1.
  - SHOW: cnt GUARD..DIV-1.
- GUARD: an_n all 1. On the cycle with cnt == GUARD-1, the block samples digit idx and moves to SHOW:
  - bcd_out ← digit idx
  - dp_out ← dp[idx]
  - bad_code ← (digit > 9)
  - an_n ← ~(1 << idx)
- Sample source: the shadow register. If load is high on the sampling cycle, the block uses bcd_in/dp_in directly (load bypass).
- bcd_out, dp_out and an_n stay stable for the whole SHOW phase; a load during SHOW does not change the lit digit.
- SHOW: on cnt == DIV-1:
  - cnt ← 0; an_n ← all 1; state ← GUARD.
  - idx ← idx+1, wrapping from NUM_DIGITS-1 to 0.
  - frame_tick ← 1 for one cycle when idx wraps.
- bcd_out and dp_out hold their last values during GUARD. Only an_n blanks.
- Codes 10..15 pass through unchanged with bad_code high. No substitution.
- en low: on the next edge an_n ← all 1, cnt ← 0, idx ← 0, state ← GUARD, frame_tick ← 0. Load still captures. When en returns high, scan restarts with the digit-0 guard.
- Asynchronous reset mid-slot: the reset values above take effect immediately; the shadow is cleared.

## Timing
- Slot length = DIV cycles. The digit is lit for exactly DIV-GUARD cycles. Frame length = NUM_DIGITS*DIV cycles.
- First lit digit after reset release with en=1: an_n[0] goes low GUARD cycles after the first active edge.
- Load-to-display latency: visible at the next SHOW entry of each digit; worst case NUM_DIGITS*DIV cycles.
- Exactly one an_n bit is low at any time, or none. There is never a transition between two lit digits without at least GUARD blank cycles.
- Counter width: $clog2(DIV). idx width: $clog2(NUM_DIGITS).

## Configuration
- SEG7_LZ_SUPPRESS_EN defined: leading-zero suppression.
  - At SHOW entry, digit i (i ≥ 1) keeps an_n all 1 for the slot if it and every higher digit in the sampled source are 0.
  - Digit 0 is always lit.
  - dp_in[i]=1 overrides suppression for that digit.
- Undefined: every digit is lit in its slot. Suppression logic is absent.

## Test plan
Bench parameters: NUM_DIGITS=4, DIV=8, GUARD=2.
- Reset release, en=1, load bcd_in=16'h1234 -> an_n=4'b1110 for cycles 2..7 with bcd_out=4; 4'b1101 with 3 for the next slot; then 2, then 1; frame_tick pulses once every 32 cycles.
- load 16'h5678 while digit 1 is in SHOW -> digit 1 holds 3 until its slot ends; digit 2 then shows 6.
- load asserted on the cnt==1 edge of digit 0 with 16'h0009 -> bcd_out=9 on that same SHOW entry (bypass).
- bcd_in=16'h00A0 -> digit 1 shows bcd_out=4'hA with bad_code=1; bad_code=0 on the other digits.
- en low for 3 cycles mid-SHOW of digit 2 -> an_n=4'b1111 next cycle; when en returns high, an_n[0] goes low 2 cycles later.
- With SEG7_LZ_SUPPRESS_EN, bcd_in=16'h0070 -> digits 3 and 2 stay blank; digits 1 and 0 light. With dp_in=4'b1000, digit 3 lights showing 0.
